myswitch_input_conditioner: RTL and testbench

- Conditions raw board switch inputs for the myswitch AXI4-Lite peripheral. Sits directly upstream of its register bank.
- Per-switch functions: 2-FF synchroniser, debounce filter, sticky rise/fall event flags (write-1-to-clear from the register bank), and a global transition counter.
- Drives a level interrupt when any enabled event flag is set.
- The register bank maps sw_state, rise_flags, fall_flags and change_count onto readable registers, and maps clears/enable onto writable ones.

---
 rtl/myswitch_input_conditioner.sv | 100 ++++++++++
 tb/tb_myswitch_input_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/myswitch_input_conditioner.sv
// Switch input conditioner: synchroniser, debounce, sticky edge flags,
// transition counter and level interrupt for the myswitch peripheral.
module myswitch_input_conditioner #(
    parameter int NUM_SW          = 8,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [NUM_SW-1:0] sw_in,
    input  logic [NUM_SW-1:0] rise_clr,
    input  logic [NUM_SW-1:0] fall_clr,
    input  logic              count_clr,
    input  logic              irq_en,
    output logic [NUM_SW-1:0] sw_state,
    output logic [NUM_SW-1:0] rise_flags,
    output logic [NUM_SW-1:0] fall_flags,
    output logic [CNT_W-1:0]  change_count,
    output logic              irq
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] s1;
    logic [NUM_SW-1:0] s2;
    logic [NUM_SW-1:0] acc;
    logic [NUM_SW-1:0] state_nxt;
    logic [NUM_SW-1:0] rise_nxt;
    logic [NUM_SW-1:0] fall_nxt;
    logic [DB_W-1:0]   db_cnt  [NUM_SW];
    logic [DB_W-1:0]   cnt_nxt [NUM_SW];
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  count_nxt;
    logic              irq_nxt;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // Any cycle where s2 agrees with the accepted level restarts the window.
    always_comb begin
        acc       = '0;
        state_nxt = sw_state;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_state[i]) begin
                if (db_cnt[i] == DB_MAX) begin
                    acc[i]       = 1'b1;
                    state_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_cnt = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            acc_cnt = acc_cnt + CNT_W'(acc[i]);
        end
    end

    always_comb begin
        rise_nxt  = (rise_flags & ~rise_clr) | (acc & state_nxt);
        fall_nxt  = (fall_flags & ~fall_clr) | (acc & ~state_nxt);
        count_nxt = (count_clr ? '0 : change_count) + acc_cnt;
        irq_nxt   = irq_en & ((|rise_flags) | (|fall_flags));
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt[i] <= '0;
            end
            sw_state     <= '0;
            rise_flags   <= '0;
            fall_flags   <= '0;
            change_count <= '0;
            irq          <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt[i] <= cnt_nxt[i];
            end
            sw_state     <= state_nxt;
            rise_flags   <= rise_nxt;
            fall_flags   <= fall_nxt;
            change_count <= count_nxt;
            irq          <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_myswitch_input_conditioner.sv
// Randomized and directed bench for myswitch_input_conditioner against a
// window-based reference model of the switch conditioning rules.
module tb_myswitch_input_conditioner;

    localparam int N = 4;
    localparam int D = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         areset;
    logic [N-1:0] sw_in;
    logic [N-1:0] rise_clr;
    logic [N-1:0] fall_clr;
    logic         count_clr;
    logic         irq_en;
    logic [N-1:0] sw_state;
    logic [N-1:0] rise_flags;
    logic [N-1:0] fall_flags;
    logic [W-1:0] change_count;
    logic         irq;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [D-1:0] hist [N];
    logic [N-1:0] m_state = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    logic [W-1:0] m_cnt = '0;
    logic         m_irq = 1'b0;

    myswitch_input_conditioner #(
        .NUM_SW(N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(W)
    ) dut (
        .ACLK(clk),
        .ARESET(areset),
        .sw_in(sw_in),
        .rise_clr(rise_clr),
        .fall_clr(fall_clr),
        .count_clr(count_clr),
        .irq_en(irq_en),
        .sw_state(sw_state),
        .rise_flags(rise_flags),
        .fall_flags(fall_flags),
        .change_count(change_count),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // A level is accepted once the last D synchronised samples all
    // disagree with the currently accepted level.
    task automatic model_step();
        logic [N-1:0] acc;
        logic [D-1:0] w;
        logic         n_irq;
        if (areset) begin
            m_s1 = '0; m_s2 = '0; m_state = '0;
            m_rise = '0; m_fall = '0; m_cnt = '0; m_irq = 1'b0;
            for (int i = 0; i < N; i++) hist[i] = '0;
            return;
        end
        acc = '0;
        for (int i = 0; i < N; i++) begin
            w = {hist[i][D-2:0], m_s2[i]};
            if (w == {D{~m_state[i]}}) acc[i] = 1'b1;
            hist[i] = w;
        end
        n_irq  = irq_en & ((|m_rise) | (|m_fall));
        m_rise = (m_rise & ~rise_clr) | (acc & ~m_state);
        m_fall = (m_fall & ~fall_clr) | (acc & m_state);
        m_cnt  = W'((count_clr ? 0 : int'(m_cnt)) + $countones(acc));
        m_state = m_state ^ acc;
        m_s2 = m_s1;
        m_s1 = sw_in;
        m_irq = n_irq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("sw_state", 32'(sw_state), 32'(m_state));
        check("rise_flags", 32'(rise_flags), 32'(m_rise));
        check("fall_flags", 32'(fall_flags), 32'(m_fall));
        check("change_count", 32'(change_count), 32'(m_cnt));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    initial begin
        logic [5:0] bounce;
        for (int i = 0; i < N; i++) hist[i] = '0;
        areset = 1'b1; sw_in = 4'hF; rise_clr = '0; fall_clr = '0;
        count_clr = 1'b0; irq_en = 1'b1;
        #2;

        repeat (3) tick();
        areset = 1'b0;
        tick();
        repeat (4) tick();
        check("rst_hold", 32'(sw_state), 32'h0);
        tick();
        check("rst_state", 32'(sw_state), 32'hF);
        check("rst_cnt", 32'(change_count), 32'd4);
        check("rst_rise", 32'(rise_flags), 32'hF);
        tick();
        check("rst_irq", 32'(irq), 32'h1);

        sw_in = 4'h0;
        repeat (8) tick();
        rise_clr = 4'hF; fall_clr = 4'hF; count_clr = 1'b1;
        tick();
        rise_clr = '0; fall_clr = '0; count_clr = 1'b0;
        repeat (2) tick();
        check("clr_irq", 32'(irq), 32'h0);
        check("clr_cnt", 32'(change_count), 32'h0);

        sw_in = 4'b0001;
        tick();
        repeat (4) tick();
        check("press_early", 32'(sw_state), 32'h0);
        tick();
        check("press_state", 32'(sw_state), 32'h1);
        check("press_rise", 32'(rise_flags), 32'h1);
        check("press_cnt", 32'(change_count), 32'h1);
        tick();
        check("press_irq", 32'(irq), 32'h1);

        rise_clr = 4'b0001;
        tick();
        rise_clr = '0;
        check("w1c_rise", 32'(rise_flags), 32'h0);
        tick();
        check("w1c_irq", 32'(irq), 32'h0);

        sw_in = 4'b0011;
        repeat (3) tick();
        sw_in = 4'b0001;
        repeat (8) tick();
        check("glitch_state", 32'(sw_state), 32'h1);
        check("glitch_cnt", 32'(change_count), 32'h1);
        check("glitch_rise", 32'(rise_flags), 32'h0);

        bounce = 6'b111101;
        for (int k = 0; k < 6; k++) begin
            sw_in[1] = bounce[k];
            tick();
        end
        tick();
        check("bounce_early", 32'(sw_state), 32'h1);
        tick();
        check("bounce_state", 32'(sw_state), 32'h3);

        sw_in = 4'b0010;
        repeat (8) tick();
        rise_clr = 4'hF; fall_clr = 4'hF;
        tick();
        rise_clr = '0; fall_clr = '0;
        sw_in = 4'b0011;
        tick();
        repeat (4) tick();
        rise_clr = 4'b0001;
        tick();
        rise_clr = '0;
        check("same_edge_rise", 32'(rise_flags), 32'h1);

        sw_in = 4'h0;
        repeat (8) tick();
        sw_in = 4'hF;
        tick();
        repeat (4) tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check("simul_cnt", 32'(change_count), 32'd4);

        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        for (int k = 0; k < 65; k++) begin
            sw_in = ~sw_in;
            repeat (8) tick();
        end
        check("wrap_cnt", 32'(change_count), 32'd4);

        sw_in = 4'b0100;
        repeat (3) tick();
        areset = 1'b1;
        repeat (2) tick();
        areset = 1'b0;
        tick();
        repeat (4) tick();
        check("midrst_early", 32'(sw_state), 32'h0);
        tick();
        check("midrst_state", 32'(sw_state), 32'h4);

        for (int k = 0; k < 4000; k++) begin
            sw_in     = sw_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom)
                                 & 4'($urandom));
            rise_clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            fall_clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            count_clr = ($urandom_range(63) == 0);
            if ($urandom_range(49) == 0) irq_en = ~irq_en;
            areset    = ($urandom_range(599) == 0);
            tick();
        end
        areset = 1'b0; rise_clr = '0; fall_clr = '0; count_clr = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
